edge_event_arbiter: RTL and testbench

EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

---
 rtl/edge_event_arbiter.sv | 235 +++++++++++++++++++++++
 tb/tb_edge_event_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter
//   Debounces NUM_INPUTS raw asynchronous inputs and turns filtered level
//   changes into edge events. Events are held per channel as pending and are
//   presented one at a time through a registered valid/ready output. Pending
//   channels are granted round-robin.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in           raw, possibly bouncing inputs (one bit per channel)
//   level        filtered level per channel
//   evt_valid    the output event register holds an event
//   evt_ready    consumer accepts the presented event
//   evt_index    channel of the presented event
//   evt_rising   1 = rising edge, 0 = falling edge
//   overrun      sticky per-channel flag: an edge replaced an unserved event
//   overrun_clr  per-channel single-cycle clear strobes
//   evt_time     (EDGE_EVENT_TIMESTAMP_EN only) cycle stamp of the event
//
// Build option
//   EDGE_EVENT_TIMESTAMP_EN: adds a free-running 16-bit cycle counter,
//   per-channel timestamp capture and the evt_time output.
module edge_event_arbiter #(
  parameter int unsigned NUM_INPUTS   = 4,
  parameter int unsigned FILTER_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_INPUTS-1:0]         in,
  output logic [NUM_INPUTS-1:0]         level,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [$clog2(NUM_INPUTS)-1:0] evt_index,
  output logic                          evt_rising,
  output logic [NUM_INPUTS-1:0]         overrun,
  input  logic [NUM_INPUTS-1:0]         overrun_clr
`ifdef EDGE_EVENT_TIMESTAMP_EN
  ,
  output logic [15:0]                   evt_time
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_INPUTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  logic [NUM_INPUTS-1:0]                   sync1_q;
  logic [NUM_INPUTS-1:0]                   sync2_q;
  logic [NUM_INPUTS-1:0][FILTER_WIDTH-1:0] shift_q;
  logic [NUM_INPUTS-1:0][FILTER_WIDTH-1:0] shift_nxt;
  logic [NUM_INPUTS-1:0]                   shift_msb_unused;
  logic [NUM_INPUTS-1:0]                   level_nxt;
  logic [NUM_INPUTS-1:0]                   level_prev_q;
  logic [NUM_INPUTS-1:0]                   chg;
  logic [NUM_INPUTS-1:0]                   pending_q;
  logic [NUM_INPUTS-1:0]                   pending_nxt;
  logic [NUM_INPUTS-1:0]                   pol_q;
  logic [NUM_INPUTS-1:0]                   pol_nxt;
  logic [NUM_INPUTS-1:0]                   ovr_set;
  logic [IDX_W-1:0]                        rr_ptr_q;
  logic [IDX_W-1:0]                        rr_ptr_nxt;
  logic [IDX_W-1:0]                        sel_idx;
  logic                                    sel_found;
  logic                                    load;
  out_state_e                              state_q;
  out_state_e                              state_nxt;

  // Two-flop synchronizer per channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
    end
  end

  // Filter: the level follows only when the shift register, as it stands
  // after this clock's shift, holds FILTER_WIDTH equal samples. Evaluating the
  // post-shift contents makes the level move in the same clock the last
  // matching sample enters, so the oldest stored sample is never consulted.
  always_comb begin
    shift_nxt        = shift_q;
    level_nxt        = level;
    shift_msb_unused = '0;
    for (int i = 0; i < int'(NUM_INPUTS); i++) begin
      shift_msb_unused[i] = shift_q[i][FILTER_WIDTH-1];
      shift_nxt[i]        = {shift_q[i][FILTER_WIDTH-2:0], sync2_q[i]};
      if (&shift_nxt[i]) begin
        level_nxt[i] = 1'b1;
      end else if (~|shift_nxt[i]) begin
        level_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q      <= '0;
      level        <= '0;
      level_prev_q <= '0;
    end else begin
      shift_q      <= shift_nxt;
      level        <= level_nxt;
      level_prev_q <= level;
    end
  end

  // A level change seen one clock after it happened.
  assign chg = level ^ level_prev_q;

  // Round-robin search upward from the pointer, wrapping at NUM_INPUTS.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < int'(NUM_INPUTS); k++) begin
      cand = 32'(rr_ptr_q) + 32'(k);
      if (cand >= NUM_INPUTS) begin
        cand = cand - NUM_INPUTS;
      end
      if (!sel_found && pending_q[cand[IDX_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Output register state: a load happens whenever the register is empty or
  // being consumed this clock and some channel is pending.
  always_comb begin
    state_nxt = state_q;
    load      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (sel_found) begin
          load      = 1'b1;
          state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (evt_ready) begin
          if (sel_found) begin
            load = 1'b1;
          end else begin
            state_nxt = ST_EMPTY;
          end
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // Pending bookkeeping. An edge on a channel that is being loaded this clock
  // re-arms it without overrun; an edge on a channel still waiting replaces
  // its polarity and flags overrun.
  always_comb begin
    pending_nxt = pending_q;
    pol_nxt     = pol_q;
    ovr_set     = '0;
    rr_ptr_nxt  = rr_ptr_q;
    if (load) begin
      pending_nxt[sel_idx] = 1'b0;
      rr_ptr_nxt           = (sel_idx == LAST_IDX) ? '0 : sel_idx + IDX_W'(1);
    end
    for (int i = 0; i < int'(NUM_INPUTS); i++) begin
      if (chg[i]) begin
        if (pending_q[i] && !(load && (sel_idx == IDX_W'(i)))) begin
          ovr_set[i] = 1'b1;
        end
        pending_nxt[i] = 1'b1;
        pol_nxt[i]     = level[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      pending_q  <= '0;
      pol_q      <= '0;
      rr_ptr_q   <= '0;
      overrun    <= '0;
      evt_index  <= '0;
      evt_rising <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      pending_q <= pending_nxt;
      pol_q     <= pol_nxt;
      rr_ptr_q  <= rr_ptr_nxt;
      // Set beats a simultaneous clear.
      overrun   <= (overrun & ~overrun_clr) | ovr_set;
      if (load) begin
        evt_index  <= sel_idx;
        evt_rising <= pol_q[sel_idx];
      end
    end
  end

  assign evt_valid = (state_q == ST_FULL);

`ifdef EDGE_EVENT_TIMESTAMP_EN
  localparam int unsigned TS_W = 16;

  logic [TS_W-1:0]                 ts_cnt_q;
  logic [NUM_INPUTS-1:0][TS_W-1:0] ts_q;

  // Free-running stamp counter; each edge (new or overwriting) re-stamps its
  // channel, and the stamp travels with the event into the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt_q <= '0;
      ts_q     <= '0;
      evt_time <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + TS_W'(1);
      for (int i = 0; i < int'(NUM_INPUTS); i++) begin
        if (chg[i]) begin
          ts_q[i] <= ts_cnt_q;
        end
      end
      if (load) begin
        evt_time <= ts_q[sel_idx];
      end
    end
  end
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Testbench for edge_event_arbiter: directed scenarios plus a randomized run,
// every cycle compared against a behavioural model built from history queues.
module tb_edge_event_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned IW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  in;
  logic [N-1:0]  level;
  logic          evt_valid;
  logic          evt_ready;
  logic [IW-1:0] evt_index;
  logic          evt_rising;
  logic [N-1:0]  overrun;
  logic [N-1:0]  overrun_clr;
`ifdef EDGE_EVENT_TIMESTAMP_EN
  logic [15:0]   evt_time;
`endif

  edge_event_arbiter #(
    .NUM_INPUTS  (N),
    .FILTER_WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in         (in),
    .level      (level),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_index  (evt_index),
    .evt_rising (evt_rising),
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
`ifdef EDGE_EVENT_TIMESTAMP_EN
    ,
    .evt_time   (evt_time)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic          rise;
    logic [15:0]   t;
  } evt_t;

  evt_t got [$];

  // Reference model: hist[k] is the input sampled k clocks ago.
  logic [N-1:0] hist [W+2];
  logic [N-1:0] m_level;
  logic [N-1:0] m_chg;
  logic [N-1:0] m_pend;
  logic [N-1:0] m_pol;
  logic [N-1:0] m_ovr;
  int           m_ptr;
  logic         m_valid;
  int           m_idx;
  logic         m_rise;
`ifdef EDGE_EVENT_TIMESTAMP_EN
  logic [15:0]  m_cnt;
  logic [15:0]  m_time;
  logic [15:0]  m_ts [N];
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < int'(W) + 2; k++) hist[k] = '0;
    m_level = '0;
    m_chg   = '0;
    m_pend  = '0;
    m_pol   = '0;
    m_ovr   = '0;
    m_ptr   = 0;
    m_valid = 1'b0;
    m_idx   = 0;
    m_rise  = 1'b0;
`ifdef EDGE_EVENT_TIMESTAMP_EN
    m_cnt  = '0;
    m_time = '0;
    for (int i = 0; i < int'(N); i++) m_ts[i] = '0;
`endif
  endtask

  // One clock of the specified behaviour, using the inputs seen at the edge.
  task automatic model_step();
    logic [N-1:0] nl;
    logic [N-1:0] np;
    logic [N-1:0] npol;
    logic [N-1:0] oset;
    bit           ld;
    int           sel;
    bit           all0;
    bit           all1;
    for (int k = int'(W) + 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = in;
    // Level follows once the W samples delayed by the synchronizer agree.
    nl = m_level;
    for (int i = 0; i < int'(N); i++) begin
      all0 = 1'b1;
      all1 = 1'b1;
      for (int k = 2; k <= int'(W) + 1; k++) begin
        if (hist[k][i]) all0 = 1'b0;
        else            all1 = 1'b0;
      end
      if (all1)      nl[i] = 1'b1;
      else if (all0) nl[i] = 1'b0;
    end
    ld  = 1'b0;
    sel = 0;
    if (!m_valid || evt_ready) begin
      for (int k = 0; k < int'(N); k++) begin
        int j;
        j = (m_ptr + k) % int'(N);
        if (!ld && m_pend[j]) begin
          ld  = 1'b1;
          sel = j;
        end
      end
    end
    np   = m_pend;
    npol = m_pol;
    oset = '0;
    if (ld) begin
      m_valid = 1'b1;
      m_idx   = sel;
      m_rise  = m_pol[sel];
      np[sel] = 1'b0;
      m_ptr   = (sel + 1) % int'(N);
`ifdef EDGE_EVENT_TIMESTAMP_EN
      m_time = m_ts[sel];
`endif
    end else if (m_valid && evt_ready) begin
      m_valid = 1'b0;
    end
    for (int i = 0; i < int'(N); i++) begin
      if (m_chg[i]) begin
        if (m_pend[i] && !(ld && sel == i)) oset[i] = 1'b1;
        np[i]   = 1'b1;
        npol[i] = m_level[i];
`ifdef EDGE_EVENT_TIMESTAMP_EN
        m_ts[i] = m_cnt;
`endif
      end
    end
    m_chg   = nl ^ m_level;
    m_level = nl;
    m_pend  = np;
    m_pol   = npol;
    m_ovr   = (m_ovr & ~overrun_clr) | oset;
`ifdef EDGE_EVENT_TIMESTAMP_EN
    m_cnt = m_cnt + 16'd1;
`endif
  endtask

  task automatic compare();
    chk("level", 32'(level), 32'(m_level));
    chk("evt_valid", 32'(evt_valid), 32'(m_valid));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    if (m_valid) begin
      chk("evt_index", 32'(evt_index), 32'(m_idx));
      chk("evt_rising", 32'(evt_rising), 32'(m_rise));
`ifdef EDGE_EVENT_TIMESTAMP_EN
      chk("evt_time", 32'(evt_time), 32'(m_time));
`endif
    end
  endtask

  task automatic tick();
    evt_t e;
    if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
      e.idx  = evt_index;
      e.rise = evt_rising;
`ifdef EDGE_EVENT_TIMESTAMP_EN
      e.t = evt_time;
`else
      e.t = '0;
`endif
      got.push_back(e);
    end
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_evt_valid", 32'(evt_valid), 32'h0);
    chk("rst_evt_index", 32'(evt_index), 32'h0);
    chk("rst_evt_rising", 32'(evt_rising), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int limit, input string tag);
    int n;
    n = 0;
    while (evt_valid !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    chk(tag, 32'(evt_valid), 32'h1);
  endtask

  initial begin
    logic [N-1:0] tgt;
    int           bounce [N];

    rst_n       = 1'b1;
    in          = '0;
    evt_ready   = 1'b0;
    overrun_clr = '0;
    #1;
    pulse_reset();

    // Single rising edge on ch2: level after W+2 clocks, then one event.
    in = 4'b0100;
    repeat (W + 1) tick();
    chk("single_level_early", 32'(level[2]), 32'h0);
    tick();
    chk("single_level", 32'(level), 32'h4);
    wait_valid(4, "single_valid");
    chk("single_index", 32'(evt_index), 32'h2);
    chk("single_rising", 32'(evt_rising), 32'h1);
    got.delete();
    evt_ready = 1'b1;
    repeat (2) tick();
    chk("single_count", 32'(got.size()), 32'h1);

    // Bounce on ch0 every 3 clocks never survives the filter.
    got.delete();
    for (int c = 0; c < 40; c++) begin
      if (c % 3 == 0) in[0] = ~in[0];
      tick();
    end
    in[0] = 1'b0;
    repeat (12) tick();
    chk("bounce_level", 32'(level[0]), 32'h0);
    chk("bounce_events", 32'(got.size()), 32'h0);
    chk("bounce_valid", 32'(evt_valid), 32'h0);

    // Round robin: ch0, ch1, ch3 rise together while stalled.
    evt_ready = 1'b0;
    in        = '0;
    pulse_reset();
    in = 4'b1011;
    wait_valid(20, "rr_valid");
    repeat (2) tick();
    got.delete();
    evt_ready = 1'b1;
    repeat (3) tick();
    chk("rr_valid_after", 32'(evt_valid), 32'h0);
    chk("rr_count", 32'(got.size()), 32'h3);
    if (got.size() == 3) begin
      chk("rr_first", 32'(got[0].idx), 32'h0);
      chk("rr_second", 32'(got[1].idx), 32'h1);
      chk("rr_third", 32'(got[2].idx), 32'h3);
      chk("rr_rising", 32'({got[0].rise, got[1].rise, got[2].rise}), 32'h7);
    end

    // Overrun: ch1 rises then falls while ch0's event is stalled.
    evt_ready = 1'b0;
    in        = '0;
    pulse_reset();
    in = 4'b0001;
    wait_valid(20, "ovr_valid");
    in = 4'b0011;
    repeat (W + 4) tick();
    in = 4'b0001;
    repeat (W + 4) tick();
    chk("ovr_set", 32'(overrun), 32'h2);
    got.delete();
    evt_ready = 1'b1;
    repeat (4) tick();
    chk("ovr_count", 32'(got.size()), 32'h2);
    if (got.size() == 2) begin
      chk("ovr_ev0_index", 32'(got[0].idx), 32'h0);
      chk("ovr_ev0_rising", 32'(got[0].rise), 32'h1);
      chk("ovr_ev1_index", 32'(got[1].idx), 32'h1);
      chk("ovr_ev1_rising", 32'(got[1].rise), 32'h0);
    end
    overrun_clr = 4'b0010;
    tick();
    overrun_clr = '0;
    chk("ovr_clr", 32'(overrun), 32'h0);

    // Reset while an event is presented and two more are pending.
    evt_ready = 1'b0;
    in        = '0;
    pulse_reset();
    in = 4'b0111;
    wait_valid(20, "mid_valid");
    tick();
    in = 4'b0001;
    pulse_reset();
    got.delete();
    evt_ready = 1'b1;
    repeat (30) tick();
    chk("mid_count", 32'(got.size()), 32'h1);
    if (got.size() == 1) begin
      chk("mid_index", 32'(got[0].idx), 32'h0);
      chk("mid_rising", 32'(got[0].rise), 32'h1);
    end

    // Randomized bouncing inputs, random back-pressure and clears.
    evt_ready = 1'b1;
    in        = '0;
    pulse_reset();
    tgt = '0;
    for (int i = 0; i < int'(N); i++) bounce[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < int'(N); i++) begin
        if ($urandom_range(0, 39) == 0) begin
          tgt[i]    = ~tgt[i];
          bounce[i] = int'($urandom_range(0, 6));
        end
        if (bounce[i] > 0) begin
          in[i] = tgt[i] ^ 1'($urandom_range(0, 1));
          bounce[i]--;
        end else begin
          in[i] = tgt[i];
        end
      end
      evt_ready   = ($urandom_range(0, 3) != 0);
      overrun_clr = ($urandom_range(0, 15) == 0) ? 4'($urandom()) : 4'h0;
      tick();
    end
    overrun_clr = '0;

`ifdef EDGE_EVENT_TIMESTAMP_EN
    // Stamps of edges 100 clocks apart differ by 100, also across a wrap.
    evt_ready = 1'b1;
    in        = '0;
    pulse_reset();
    got.delete();
    in = 4'b0100;
    repeat (100) tick();
    in = 4'b1100;
    repeat (30) tick();
    chk("ts_count", 32'(got.size()), 32'h2);
    if (got.size() == 2) chk("ts_delta", 32'(16'(got[1].t - got[0].t)), 32'd100);
    while (m_cnt != 16'hFFB0) tick();
    got.delete();
    in = 4'b1000;
    repeat (100) tick();
    in = 4'b0000;
    repeat (30) tick();
    chk("ts_wrap_count", 32'(got.size()), 32'h2);
    if (got.size() == 2) begin
      chk("ts_wrap_delta", 32'(16'(got[1].t - got[0].t)), 32'd100);
      chk("ts_wrap_order", 32'(got[1].t < got[0].t), 32'h1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
